// File: rtl/param_sync_fifo.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow errors and a synchronous flush.
module param_sync_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_LEVEL  = 6,
    parameter int AEMPTY_LEVEL = 1,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    wr_ptr_nxt;
    logic             wr_en;

    // Handshake: we/re are single-cycle requests acted on at the next edge;
    // there is no ready - a write to a full FIFO (without re) is dropped and
    // flagged, a read from an empty FIFO is ignored and flagged.
    assign wr_en = reset_n && !flush && we && (re || !full);

    assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({we, re})
                2'b10: begin
                    if (!full) begin
                        wr_ptr <= wr_ptr_nxt;
                        count  <= count + ONE;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        rd_ptr <= rd_ptr_nxt;
                        count  <= count - ONE;
                    end else begin
                        underflow <= 1'b1;
                    end
                end
                2'b11: begin
                    // When full, wr_ptr == rd_ptr: the new word lands in the slot being popped.
                    wr_ptr <= wr_ptr_nxt;
                    if (!empty) begin
                        rd_ptr <= rd_ptr_nxt;
                    end else begin
                        count     <= ONE;
                        underflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_LEVEL));
    assign almost_empty = (count <= CW'(AEMPTY_LEVEL));
    assign data_out     = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: drivers push expected words into exp_q,
// a negedge monitor pops and compares every word the DUT hands out on a read.
module tb_param_sync_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    logic [WIDTH-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    param_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .data_in(data_in),
        .we(we), .re(re), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard monitor: a read of a non-empty FIFO presents the head word
    always @(negedge clock) begin
        if (reset_n && !flush && re && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_data: got %h, expected nothing (queue empty)", data_out);
            end else begin
                logic [WIDTH-1:0] exp_w;
                exp_w = exp_q.pop_front();
                if (data_out !== exp_w) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", data_out, exp_w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // driver tasks; 'accept' is the hand-decided fate of the written word
    task automatic do_write(input logic [WIDTH-1:0] d, input bit accept);
        we = 1'b1; re = 1'b0; data_in = d;
        if (accept) exp_q.push_back(d);
        cycle();
        we = 1'b0;
    endtask

    task automatic do_read();
        we = 1'b0; re = 1'b1;
        cycle();
        re = 1'b0;
    endtask

    task automatic do_wr_rd(input logic [WIDTH-1:0] d);
        we = 1'b1; re = 1'b1; data_in = d;
        exp_q.push_back(d);
        cycle();
        we = 1'b0; re = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; data_in = '0;
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();

        // 1: reset state
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_count", count, 0);
        check("rst_data_out", data_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);

        // 2: fill, watching count and flags
        for (int i = 0; i < 8; i++) begin
            do_write(32'hA0 + i, 1'b1);
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
            check("fill_full", full, (i == 7) ? 1 : 0);
            check("fill_aempty", almost_empty, (i == 0) ? 1 : 0);
            check("fill_head", data_out, 32'hA0);
        end

        // 3: write alone when full is dropped
        do_write(32'hFF, 1'b0);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_head", data_out, 32'hA0);

        // 4: push+pop when full
        do_wr_rd(32'hB0);
        check("pp_full_count", count, 8);
        check("pp_full_head", data_out, 32'hA1);
        check("pp_full_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) do_read();
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        check("drain_data_out", data_out, 0);
        check("drain_underflow", underflow, 0);

        // 5: underflow, then push+pop on empty
        do_read();
        check("udf_flag", underflow, 1);
        check("udf_count", count, 0);
        do_wr_rd(32'h11);
        check("pp_empty_count", count, 1);
        check("pp_empty_data", data_out, 32'h11);
        check("pp_empty_udf", underflow, 1);

        // 6: flush with a concurrent write
        for (int i = 0; i < 4; i++) do_write(32'h21 + i, 1'b1);
        check("pre_flush_count", count, 5);
        check("pre_flush_ovf", overflow, 1);
        flush = 1'b1; we = 1'b1; data_in = 32'h99;
        cycle();
        flush = 1'b0; we = 1'b0;
        exp_q.delete();
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_ovf", overflow, 0);
        check("flush_udf", underflow, 0);
        check("flush_data_out", data_out, 0);
        do_write(32'h55, 1'b1);
        check("post_flush_count", count, 1);
        check("post_flush_head", data_out, 32'h55);
        do_read();

        // 7: pointer wrap at count ~3
        for (int i = 0; i < 3; i++) do_write(32'h100 + i, 1'b1);
        for (int i = 0; i < 10; i++) begin
            do_write(32'h200 + i, 1'b1);
            check("wrap_count_w", count, 4);
            do_read();
            check("wrap_count_r", count, 3);
        end
        for (int i = 0; i < 10; i++) begin
            do_wr_rd(32'h300 + i);
            check("wrap_count_pp", count, 3);
        end
        for (int i = 0; i < 3; i++) do_read();
        check("final_empty", empty, 1);
        check("final_queue", exp_q.size(), 0);
        check("final_udf", underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
